// File: rtl/regfile_dump_reader.sv
// Walks register-file debug reads START_IDX..END_IDX onto a valid/ready stream with a running sum.
// Each word takes 2 cycles minimum; out_valid holds its word until accepted, and drops early only on abort.
module regfile_dump_reader #(
  parameter int START_IDX = 0,
  parameter int END_IDX   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  reg_index,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic [31:0] checksum,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(START_IDX);
  localparam logic [4:0] LAST_IDX  = 5'(END_IDX);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t state;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      reg_index <= FIRST_IDX;
      out_valid <= 1'b0;
      out_index <= 5'd0;
      out_data  <= 32'd0;
      checksum  <= 32'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          reg_index <= FIRST_IDX;
          if (start && !abort) begin
            checksum <= 32'd0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            state     <= IDLE;
            reg_index <= FIRST_IDX;
            out_valid <= 1'b0;
          end else begin
            // Value is captured here; later register-file writes do not affect this word.
            out_data  <= reg_data;
            out_index <= reg_index;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Abort beats a coincident handshake: the word is treated as not accepted.
          if (abort) begin
            state     <= IDLE;
            reg_index <= FIRST_IDX;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (reg_index == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              reg_index <= reg_index + 5'd1;
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          reg_index <= FIRST_IDX;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          reg_index <= FIRST_IDX;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: per-cycle vector table for a full dump plus hand sequences for reset, stall, abort and wrap.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst;
  logic        start, abort, out_ready;
  logic [4:0]  reg_index;
  logic [31:0] reg_data;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] out_data, checksum;
  logic        busy, done;

  logic        start2, abort2, out_ready2;
  logic [4:0]  reg_index2;
  logic [31:0] reg_data2;
  logic        out_valid2;
  logic [4:0]  out_index2;
  logic [31:0] out_data2, checksum2;
  logic        busy2, done2;

  logic [31:0] regs [32];

  int n_cmp;
  int n_fail;

  regfile_dump_reader #(.START_IDX(0), .END_IDX(31)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .reg_index(reg_index), .reg_data(reg_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .checksum(checksum), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.START_IDX(1), .END_IDX(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .reg_index(reg_index2), .reg_data(reg_data2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_index(out_index2), .out_data(out_data2),
    .checksum(checksum2), .busy(busy2), .done(done2)
  );

  // Register-file model: combinational read, register 0 hard-wired to zero.
  always_comb begin
    reg_data  = (reg_index == 5'd0) ? 32'd0 : regs[reg_index];
    reg_data2 = (reg_index2 == 5'd0) ? 32'd0 : regs[reg_index2];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_index;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs [1:66];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    int found;
    int words2, dones2;
    n_cmp = 0;
    n_fail = 0;
    start = 0; abort = 0; out_ready = 0;
    start2 = 0; abort2 = 0; out_ready2 = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[5] = 32'hDEADBEEF;

    // Per-cycle expectations for a full 0..31 dump with r_i = i and out_ready held high.
    for (int c = 1; c <= 66; c++) begin
      vecs[c].start = (c == 1);
      vecs[c].abort = 1'b0;
      vecs[c].ready = 1'b1;
      vecs[c].exp_valid = 1'b0;
      vecs[c].exp_index = 5'd0;
      vecs[c].exp_data  = 32'd0;
      vecs[c].exp_busy  = 1'b1;
      vecs[c].exp_done  = 1'b0;
      vecs[c].exp_sum   = 32'd0;
      if (c == 65) begin
        vecs[c].exp_done = 1'b1;
        vecs[c].exp_sum  = 32'd496;
      end else if (c == 66) begin
        vecs[c].exp_busy = 1'b0;
        vecs[c].exp_sum  = 32'd496;
      end else if (c >= 2 && (c % 2) == 0) begin
        vecs[c].exp_valid = 1'b1;
        vecs[c].exp_index = 5'((c - 2) / 2);
        vecs[c].exp_data  = 32'((c - 2) / 2);
        vecs[c].exp_sum   = 32'((((c - 2) / 2) * (((c - 2) / 2) - 1)) / 2);
      end else if (c >= 3) begin
        vecs[c].exp_sum   = 32'((((c - 3) / 2) * (((c - 3) / 2) + 1)) / 2);
      end
    end

    rst = 1'b0;
    #12;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", checksum, 0);
    check("reset_index", out_index, 0);
    check("reset_data", out_data, 0);
    check("reset_reg_index", reg_index, 0);
    check("reset_reg_index2", reg_index2, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Reset in the middle of a stalled SEND at index 5.
    out_ready = 1; start = 1;
    tick();
    start = 0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (out_valid && out_index == 5'd5) found = 1;
    end
    check("t1_reach_idx5", found, 1);
    out_ready = 0;
    tick();
    check("t1_stall_valid", out_valid, 1);
    check("t1_stall_data", out_data, 32'hDEADBEEF);
    check("t1_stall_sum", checksum, 32'd10);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_valid", out_valid, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_sum", checksum, 0);
    check("t1_rst_reg_index", reg_index, 0);
    check("t1_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    regs[5] = 32'd5;
    tick();
    check("t1_after_done", done, 0);
    check("t1_after_busy", busy, 0);

    // Full dump driven from the vector table.
    for (int c = 1; c <= 66; c++) begin
      start = vecs[c].start;
      abort = vecs[c].abort;
      out_ready = vecs[c].ready;
      tick();
      check($sformatf("t2_valid_c%0d", c), out_valid, vecs[c].exp_valid);
      check($sformatf("t2_busy_c%0d", c), busy, vecs[c].exp_busy);
      check($sformatf("t2_done_c%0d", c), done, vecs[c].exp_done);
      check($sformatf("t2_sum_c%0d", c), checksum, vecs[c].exp_sum);
      if (vecs[c].exp_valid) begin
        check($sformatf("t2_index_c%0d", c), out_index, vecs[c].exp_index);
        check($sformatf("t2_data_c%0d", c), out_data, vecs[c].exp_data);
      end
    end
    start = 0;

    // Backpressure at index 3 with the source register rewritten mid-stall.
    regs[3] = 32'h12345678;
    out_ready = 1; start = 1;
    tick();
    start = 0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (out_valid && out_index == 5'd3) found = 1;
    end
    check("t3_reach_idx3", found, 1);
    out_ready = 0;
    for (int s = 0; s < 5; s++) begin
      if (s == 0) regs[3] = 32'd0;
      tick();
      check($sformatf("t3_stall_valid_%0d", s), out_valid, 1);
      check($sformatf("t3_stall_index_%0d", s), out_index, 3);
      check($sformatf("t3_stall_data_%0d", s), out_data, 32'h12345678);
    end
    out_ready = 1;
    tick();
    check("t3_accept_valid", out_valid, 0);
    check("t3_accept_sum", checksum, 32'h1234567B);

    // Start while busy is ignored; abort coincident with a handshake wins.
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (out_valid && out_index == 5'd10) found = 1;
    end
    check("t4_reach_idx10", found, 1);
    start = 1;
    tick();
    start = 0;
    check("t4_busy_after_start", busy, 1);
    check("t4_sum_not_cleared", checksum, 32'h123456AC);
    tick();
    check("t4_next_valid", out_valid, 1);
    check("t4_next_index", out_index, 11);
    check("t4_next_data", out_data, 11);
    tick();
    tick();
    check("t4_idx12_valid", out_valid, 1);
    check("t4_idx12_index", out_index, 12);
    abort = 1;
    tick();
    abort = 0;
    check("t4_abort_valid", out_valid, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_sum", checksum, 32'h123456B7);
    check("t4_abort_reg_index", reg_index, 0);
    tick();
    check("t4_post_done", done, 0);
    check("t4_post_busy", busy, 0);

    // Start and abort together in IDLE.
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    check("t6_busy", busy, 0);
    check("t6_valid", out_valid, 0);
    check("t6_sum", checksum, 32'h123456B7);
    tick();
    check("t6_busy_later", busy, 0);

    // Two-word dump on the 1..2 instance with checksum wrap.
    regs[1] = 32'hFFFFFFFF;
    regs[2] = 32'h00000002;
    out_ready2 = 1; start2 = 1;
    tick();
    start2 = 0;
    words2 = 0;
    dones2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid2) begin
        words2++;
        if (words2 == 1) begin
          check("t5_w1_index", out_index2, 1);
          check("t5_w1_data", out_data2, 32'hFFFFFFFF);
        end else if (words2 == 2) begin
          check("t5_w2_index", out_index2, 2);
          check("t5_w2_data", out_data2, 32'h2);
        end
      end
      if (done2) dones2++;
    end
    check("t5_words", words2, 2);
    check("t5_done_pulses", dones2, 1);
    check("t5_sum", checksum2, 32'h00000001);
    check("t5_busy", busy2, 0);
    check("t5_reg_index", reg_index2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
